// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiplier, restoring divider,
// plus MFHI/MFLO/MTHI/MTLO service with a combinational stall back to decode.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mf_valid,
    output logic [WIDTH-1:0] mf_data
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_MUL   = 2'b01;
    localparam logic [1:0] ST_DIV   = 2'b10;
    localparam logic [1:0] ST_FIXUP = 2'b11;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   rs_cap_q, rs_cap_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               mf_valid_q, mf_valid_d;
    logic [WIDTH-1:0]   mf_data_q, mf_data_d;

    logic               hit_s;
    logic               accept_s;
    logic               signed_op_s;
    logic [WIDTH-1:0]   rs_abs_s;
    logic [WIDTH-1:0]   rt_abs_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quot_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    // Decode-side handshake; stall depends only on the busy register to avoid loops.
    always_comb begin
        hit_s = issue_valid && (opcode == 6'b000000) &&
                ((func == F_MFHI) || (func == F_MTHI) || (func == F_MFLO) || (func == F_MTLO) ||
                 (func == F_MULT) || (func == F_MULTU) || (func == F_DIV) || (func == F_DIVU));
        accept_s    = hit_s && !busy_q;
        stall       = hit_s && busy_q;
        signed_op_s = !func[0];
        rs_abs_s    = (signed_op_s && rs_data[WIDTH-1]) ? (~rs_data + WIDTH'(1)) : rs_data;
        rt_abs_s    = (signed_op_s && rt_data[WIDTH-1]) ? (~rt_data + WIDTH'(1)) : rt_data;
    end

    // Per-iteration arithmetic and final sign correction.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q} + {1'b0, opnd_q};
        div_shift_s = {acc_q, mq_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_q};
        prod_s      = {acc_q, mq_q};
        prod_fix_s  = neg_lo_q ? (~prod_s + (2*WIDTH)'(1)) : prod_s;
        quot_fix_s  = neg_lo_q ? (~mq_q + WIDTH'(1)) : mq_q;
        rem_fix_s   = neg_hi_q ? (~acc_q + WIDTH'(1)) : acc_q;
    end

    // Next-state logic for the sequencer, datapath and HI/LO.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        opnd_d     = opnd_q;
        rs_cap_d   = rs_cap_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        is_div_d   = is_div_q;
        div0_d     = div0_q;
        ovf_d      = ovf_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mf_valid_d = 1'b0;
        mf_data_d  = mf_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (func)
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            state_d  = func[1] ? ST_DIV : ST_MUL;
                            cnt_d    = CW'(WIDTH);
                            acc_d    = {WIDTH{1'b0}};
                            mq_d     = rs_abs_s;
                            opnd_d   = rt_abs_s;
                            rs_cap_d = rs_data;
                            neg_lo_d = signed_op_s && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                            neg_hi_d = signed_op_s && rs_data[WIDTH-1];
                            is_div_d = func[1];
                            div0_d   = func[1] && (rt_data == {WIDTH{1'b0}});
                            ovf_d    = func[1] && signed_op_s && (rs_data == MIN_NEG) &&
                                       (rt_data == ALL_ONES);
                        end
                        F_MTHI: hi_d = rs_data;
                        F_MTLO: lo_d = rs_data;
                        F_MFHI: begin
                            mf_valid_d = 1'b1;
                            mf_data_d  = hi_q;
                        end
                        F_MFLO: begin
                            mf_valid_d = 1'b1;
                            mf_data_d  = lo_q;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mq_q[0]) begin
                    acc_d = mul_sum_s[WIDTH:1];
                    mq_d  = {mul_sum_s[0], mq_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[WIDTH-1:1]};
                    mq_d  = {acc_q[0], mq_q[WIDTH-1:1]};
                end
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? ST_FIXUP : ST_MUL;
            end
            ST_DIV: begin
                // Restoring step: keep the difference only when it does not borrow.
                if (!div_diff_s[WIDTH]) begin
                    acc_d = div_diff_s[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift_s[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                end
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? ST_FIXUP : ST_DIV;
            end
            ST_FIXUP: begin
                if (!is_div_q) begin
                    hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix_s[WIDTH-1:0];
                end else if (div0_q) begin
                    hi_d = rs_cap_q;
                    lo_d = ALL_ONES;
                end else if (ovf_q) begin
                    hi_d = {WIDTH{1'b0}};
                    lo_d = MIN_NEG;
                end else begin
                    hi_d = rem_fix_s;
                    lo_d = quot_fix_s;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State registers with synchronous reset; reset discards any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            acc_q      <= {WIDTH{1'b0}};
            mq_q       <= {WIDTH{1'b0}};
            opnd_q     <= {WIDTH{1'b0}};
            rs_cap_q   <= {WIDTH{1'b0}};
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            is_div_q   <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            mf_valid_q <= 1'b0;
            mf_data_q  <= {WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            opnd_q     <= opnd_d;
            rs_cap_q   <= rs_cap_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            is_div_q   <= is_div_d;
            div0_q     <= div0_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mf_valid_q <= mf_valid_d;
            mf_data_q  <= mf_data_d;
        end
    end

    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign mf_valid = mf_valid_q;
    assign mf_data  = mf_data_q;

endmodule
